// File: rtl/add64_seq_ctrl_if.sv
// add64_seq_ctrl_if: requester handshake plus shared adder-slice bus.
// slave = sequencer side, master = requester/slice side.
interface add64_seq_ctrl_if #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
);
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s_out;
  logic             c_out;
  logic             ovf;
  logic [SLICE-1:0] sl_a;
  logic [SLICE-1:0] sl_b;
  logic             sl_cin;
  logic [SLICE-1:0] sl_sum;
  logic             sl_cout;

  modport slave (
    input  start, op_sub, a_in, b_in, c_in,
    input  sl_sum, sl_cout,
    output busy, done, s_out, c_out, ovf,
    output sl_a, sl_b, sl_cin
  );

  modport master (
    output start, op_sub, a_in, b_in, c_in,
    output sl_sum, sl_cout,
    input  busy, done, s_out, c_out, ovf,
    input  sl_a, sl_b, sl_cin
  );
endinterface

// File: rtl/add64_seq_ctrl.sv
// add64_seq_ctrl: multi-beat WIDTH-bit add/sub over an external SLICE adder.
// Ports: clk, rst (sync, high), bus (slave): start/op/operands in,
// busy/done/s_out/c_out/ovf out, sl_a/sl_b/sl_cin out, sl_sum/sl_cout in.
module add64_seq_ctrl #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  add64_seq_ctrl_if.slave  bus
);
  localparam int NBEATS = WIDTH / SLICE;
  localparam int BW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(NBEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [BW-1:0]    beat_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] s_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;

  logic             run;
  logic [SLICE-1:0] lane_a;
  logic [SLICE-1:0] lane_b;

  assign run    = (state_q == RUN);
  assign lane_a = a_q[int'(beat_q)*SLICE +: SLICE];
  assign lane_b = b_q[int'(beat_q)*SLICE +: SLICE];

  // Slice inputs are forced to zero outside RUN so the slice stays quiet.
  assign bus.sl_a   = run ? lane_a : '0;
  assign bus.sl_b   = run ? lane_b : '0;
  assign bus.sl_cin = run & carry_q;

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.s_out = s_q;
  assign bus.c_out = cout_q;
  assign bus.ovf   = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            // Subtract is a + ~b + 1; s_q keeps the old result.
            a_q     <= bus.a_in;
            b_q     <= bus.op_sub ? ~bus.b_in : bus.b_in;
            carry_q <= bus.op_sub ? 1'b1 : bus.c_in;
            beat_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          s_q[int'(beat_q)*SLICE +: SLICE] <= bus.sl_sum;
          carry_q <= bus.sl_cout;
          beat_q  <= beat_q + 1'b1;
          if (beat_q == LAST) begin
            cout_q  <= bus.sl_cout;
            // b_q is already inverted for subtract, so one rule covers both.
            ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                       (bus.sl_sum[SLICE-1] != a_q[WIDTH-1]);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_add64_seq_ctrl.sv
// tb_add64_seq_ctrl: directed vectors, scoreboard queue and done monitor.
// The slice is modelled as {sl_cout, sl_sum} = sl_a + sl_b + sl_cin.
module tb_add64_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  add64_seq_ctrl_if #(.WIDTH(64), .SLICE(16)) bus ();

  add64_seq_ctrl #(.WIDTH(64), .SLICE(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign {bus.sl_cout, bus.sl_sum} =
    {1'b0, bus.sl_a} + {1'b0, bus.sl_b} + {16'd0, bus.sl_cin};

  typedef struct packed {
    logic [63:0] s;
    logic        c;
    logic        v;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.done === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("s_out", bus.s_out, e.s);
          chk("c_out", {63'd0, bus.c_out}, {63'd0, e.c});
          chk("ovf", {63'd0, bus.ovf}, {63'd0, e.v});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic sub, input logic [63:0] a,
                       input logic [63:0] b, input logic ci,
                       input logic push, input exp_t e);
    bus.start  = 1'b1;
    bus.op_sub = sub;
    bus.a_in   = a;
    bus.b_in   = b;
    bus.c_in   = ci;
    if (push) sbq.push_back(e);
    tick();
    bus.start = 1'b0;
  endtask

  // Returns edges since the start was sampled, counting that edge as 1.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (bus.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus.done !== 1'b1) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input string name, input logic sub,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic ci, input logic [63:0] s,
                        input logic c, input logic v);
    int n;
    issue(sub, a, b, ci, 1'b1, '{s: s, c: c, v: v});
    chk({name, "_busy"}, {63'd0, bus.busy}, 64'd1);
    wait_done(1, n);
    chk({name, "_lat"}, 64'(n), 64'd5);
    tick();
  endtask

  initial begin
    int n;
    bus.start  = 1'b0;
    bus.op_sub = 1'b0;
    bus.a_in   = '0;
    bus.b_in   = '0;
    bus.c_in   = 1'b0;
    tick();
    tick();
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_s", bus.s_out, 64'd0);
    chk("rst_flags", {62'd0, bus.c_out, bus.ovf}, 64'd0);
    rst = 1'b0;
    tick();

    run_op("t1", 1'b0, 64'hF0F0F0F0F0F0F0F0, 64'h0F0F0F0F0F0F0F0F, 1'b0,
           64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0);
    chk("idle_sl_a", {48'd0, bus.sl_a}, 64'd0);
    chk("idle_sl_b", {47'd0, bus.sl_cin, bus.sl_b}, 64'd0);
    run_op("t2", 1'b0, 64'h0000FFFFFFFFFFFF, 64'd1, 1'b0,
           64'h0001000000000000, 1'b0, 1'b0);
    run_op("t3a", 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1,
           64'd0, 1'b1, 1'b0);
    run_op("t3b", 1'b0, 64'h7FFFFFFFFFFFFFFF, 64'd1, 1'b0,
           64'h8000000000000000, 1'b0, 1'b1);
    run_op("t4a", 1'b1, 64'd5, 64'd7, 1'b0,
           64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0);
    run_op("t4b", 1'b1, 64'd7, 64'd5, 1'b0, 64'd2, 1'b1, 1'b0);

    // Start while RUN must be ignored.
    issue(1'b0, 64'h1234, 64'h1111, 1'b0, 1'b1,
          '{s: 64'h2345, c: 1'b0, v: 1'b0});
    issue(1'b1, 64'hDEAD, 64'hBEEF, 1'b1, 1'b0, '0);
    wait_done(2, n);
    chk("t5_busy_lat", 64'(n), 64'd5);
    tick();
    chk("t5_no_restart", {63'd0, bus.busy}, 64'd0);

    // Back-to-back: start held during the DONE cycle.
    issue(1'b0, 64'h100, 64'h23, 1'b1, 1'b1,
          '{s: 64'h124, c: 1'b0, v: 1'b0});
    wait_done(1, n);
    chk("t5_b2b_lat1", 64'(n), 64'd5);
    issue(1'b1, 64'd0, 64'd1, 1'b0, 1'b1,
          '{s: 64'hFFFFFFFFFFFFFFFF, c: 1'b0, v: 1'b0});
    chk("t5_b2b_nodone", {63'd0, bus.done}, 64'd0);
    chk("t5_b2b_busy", {63'd0, bus.busy}, 64'd1);
    wait_done(1, n);
    chk("t5_b2b_lat2", 64'(n), 64'd5);
    tick();

    // Reset on beat 2 aborts with no done pulse.
    issue(1'b0, 64'h5555, 64'h1111, 1'b0, 1'b0, '0);
    tick();
    tick();
    chk("t6_busy_pre", {63'd0, bus.busy}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", {63'd0, bus.busy}, 64'd0);
    chk("t6_s", bus.s_out, 64'd0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done === 1'b1) n++;
      tick();
    end
    chk("t6_no_done", 64'(n), 64'd0);
    run_op("t6_after", 1'b0, 64'd3, 64'd4, 1'b0, 64'd7, 1'b0, 1'b0);

    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
